dma_copy: RTL and testbench

DMA_COPY -- requirements
Module: dma_copy

---
 rtl/dma_copy_pkg.sv | 17 +
 rtl/Reg.sv | 15 +
 rtl/dma_copy.sv | 144 ++++++++++++++
 tb/tb_dma_copy.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_copy_pkg.sv
// Shared encodings and default widths for the dma_copy word-copy engine.
package dma_copy_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_e;
endpackage

// File: rtl/Reg.sv
// Generic load-enabled register with synchronous active-high clear.
module Reg #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/dma_copy.sv
// Single-channel memory-to-memory word copier (read, wait, write per word).
// Optional constant-fill mode is compiled in when DMA_FILL_EN is defined.
module dma_copy #(
  parameter int ADDR_W = dma_copy_pkg::ADDR_W,
  parameter int DATA_W = dma_copy_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        count,
`ifdef DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
`endif
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              done
);
  import dma_copy_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [7:0]        rem_q, rem_d;
  logic              buf_en;
  logic [DATA_W-1:0] buf_d, buf_q;
`ifdef DMA_FILL_EN
  logic              fill_q, fill_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
`ifdef DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
`ifdef DMA_FILL_EN
      fill_q  <= fill_d;
`endif
    end
  end

  // Word buffer only loads in RDW (or from fill_value on a fill start).
  Reg #(.n(DATA_W)) u_buf (
    .clk   (clk),
    .reset (reset),
    .en    (buf_en),
    .d     (buf_d),
    .q     (buf_q)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_en  = 1'b0;
    buf_d   = read_data;
`ifdef DMA_FILL_EN
    fill_d  = fill_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          rem_d = count;
`ifdef DMA_FILL_EN
          fill_d = fill;
`endif
          if (count == 8'd0) begin
            state_d = FIN;
          end else begin
`ifdef DMA_FILL_EN
            if (fill) begin
              state_d = WR;
              buf_en  = 1'b1;
              buf_d   = fill_value;
            end else begin
              state_d = RD;
            end
`else
            state_d = RD;
`endif
          end
        end
      end
      RD:  state_d = RDW;
      RDW: begin
        buf_en  = 1'b1;
        state_d = WR;
      end
      WR: begin
        src_d = src_q + 1'b1;
        dst_d = dst_q + 1'b1;
        rem_d = rem_q - 8'd1;
        if (rem_d == 8'd0) begin
          state_d = FIN;
        end else begin
`ifdef DMA_FILL_EN
          state_d = fill_q ? WR : RD;
`else
          state_d = RD;
`endif
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_cmd  = MNONE;
    mem_addr = '0;
    busy     = (state_q != IDLE);
    done     = (state_q == FIN);
    case (state_q)
      RD, RDW: begin
        mem_cmd  = MREAD;
        mem_addr = src_q;
      end
      WR: begin
        mem_cmd  = MWRITE;
        mem_addr = dst_q;
      end
      default: ;
    endcase
  end

  assign write_data = buf_q;
endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: bus responder RAM, reference copy model and write/read scoreboards.
module tb_dma_copy;
  import dma_copy_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0]    count;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data, read_data;
  logic          busy, done;
`ifdef DMA_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_value;
`endif

  dma_copy #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .count      (count),
`ifdef DMA_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:511];
  logic [DW-1:0] mdl [0:511];

  always @(posedge clk) begin
    if (mem_cmd == MWRITE) ram[mem_addr] <= write_data;
    if (mem_cmd == MREAD)  read_data <= ram[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  int            busy_cyc, done_cnt, done_at, wr_cnt, rd_cnt;
  logic [1:0]    prev_cmd = 2'b00;

  always @(negedge clk) begin
    wr_t w;
    logic [AW-1:0] ra;
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      done_at = busy_cyc;
    end
    if (mem_cmd == MWRITE) begin
      wr_cnt++;
      chk("wr_pending", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        chk("wr_addr", mem_addr, w.a);
        chk("wr_data", write_data, w.d);
      end
    end
    if (mem_cmd == MREAD && prev_cmd != MREAD) begin
      rd_cnt++;
      chk("rd_pending", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) begin
        ra = exp_rd.pop_front();
        chk("rd_addr", mem_addr, ra);
      end
    end
    prev_cmd = mem_cmd;
  end

  // Reference model: strict ascending word copy over the model memory.
  task automatic push_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int cnt, input int nrd, input int nwr);
    logic [AW-1:0] sa, da;
    logic [DW-1:0] w;
    sa = s;
    da = d;
    for (int i = 0; i < cnt; i++) begin
      if (i < nrd) exp_rd.push_back(sa);
      w = mdl[sa];
      if (i < nwr) begin
        exp_wr.push_back('{a: da, d: w});
        mdl[da] = w;
      end
      sa = sa + 1'b1;
      da = da + 1'b1;
    end
  endtask

  task automatic clear_stats();
    busy_cyc = 0;
    done_cnt = 0;
    done_at  = 0;
    wr_cnt   = 0;
    rd_cnt   = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [7:0] c);
    src_addr = s;
    dst_addr = d;
    count    = c;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt > 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_ram(input string tag, input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      chk(tag, ram[a], mdl[a]);
    end
  endtask

  task automatic chk_queues(input string tag);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_rd_left"}, exp_rd.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i] = 16'h5000 ^ 16'(i * 7);
    end
    ram[9'h010] = 16'h00A1;
    ram[9'h011] = 16'h00B2;
    ram[9'h012] = 16'h00C3;
    for (int i = 0; i < 512; i++) mdl[i] = ram[i];

    reset = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    count = '0;
`ifdef DMA_FILL_EN
    fill = 1'b0;
    fill_value = '0;
`endif
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd", mem_cmd, MNONE);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", write_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic 3-word copy
    clear_stats();
    push_copy(9'h010, 9'h020, 3, 3, 3);
    do_start(9'h010, 9'h020, 8'd3);
    wait_done("t1");
    chk("t1_busy", busy_cyc, 10);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_at", done_at, 10);
    chk_ram("t1_ram", 9'h020, 3);
    chk("t1_ram_a1", ram[9'h020], 16'h00A1);
    chk("t1_ram_c3", ram[9'h022], 16'h00C3);
    chk("t1_wdata_hold", write_data, 16'h00C3);
    chk_queues("t1");

    // Zero-length transfer
    clear_stats();
    do_start(9'h005, 9'h006, 8'd0);
    wait_done("t2");
    chk("t2_busy", busy_cyc, 1);
    chk("t2_done_at", done_at, 1);
    chk("t2_wr_cnt", wr_cnt, 0);
    chk("t2_rd_cnt", rd_cnt, 0);

    // Source address wrap
    clear_stats();
    push_copy(9'h1FE, 9'h0F0, 3, 3, 3);
    do_start(9'h1FE, 9'h0F0, 8'd3);
    wait_done("t3");
    chk("t3_busy", busy_cyc, 10);
    chk("t3_rd_cnt", rd_cnt, 3);
    chk_ram("t3_ram", 9'h0F0, 3);
    chk_queues("t3");

    // start during a transfer is ignored
    clear_stats();
    push_copy(9'h060, 9'h068, 2, 2, 2);
    do_start(9'h060, 9'h068, 8'd2);
    repeat (3) @(posedge clk);
    #1;
    src_addr = 9'h070;
    dst_addr = 9'h071;
    count    = 8'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_done("t4");
    chk("t4_wr_cnt", wr_cnt, 2);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy", busy_cyc, 7);
    chk_ram("t4_ram", 9'h068, 2);
    chk_queues("t4");

    // Reset abort before the second write
    clear_stats();
    push_copy(9'h030, 9'h050, 3, 2, 1);
    do_start(9'h030, 9'h050, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_cmd_after_rst", mem_cmd, MNONE);
    chk("t5_busy_after_rst", busy, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_wr_cnt", wr_cnt, 1);
    chk_ram("t5_ram", 9'h050, 3);
    chk_queues("t5");

    // Overlapping regions copied in ascending order
    clear_stats();
    push_copy(9'h080, 9'h081, 3, 3, 3);
    do_start(9'h080, 9'h081, 8'd3);
    wait_done("t6");
    chk_ram("t6_ram", 9'h080, 4);
    chk("t6_ram_last", ram[9'h083], mdl[9'h080]);
    chk_queues("t6");

    // I/O addresses issued unchanged
    clear_stats();
    push_copy(9'h140, 9'h100, 2, 2, 2);
    do_start(9'h140, 9'h100, 8'd2);
    wait_done("t7");
    chk("t7_busy", busy_cyc, 7);
    chk_ram("t7_ram", 9'h100, 2);
    chk_queues("t7");

`ifdef DMA_FILL_EN
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back('{a: 9'h040 + AW'(i), d: 16'hFFFF});
      mdl[9'h040 + AW'(i)] = 16'hFFFF;
    end
    fill = 1'b1;
    fill_value = 16'hFFFF;
    do_start(9'h000, 9'h040, 8'd4);
    fill = 1'b0;
    wait_done("t8");
    chk("t8_busy", busy_cyc, 5);
    chk("t8_rd_cnt", rd_cnt, 0);
    chk_ram("t8_ram", 9'h040, 4);
    chk_queues("t8");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
